stream_writer_notify_sink: RTL and testbench

//  Consumer side of the stream writer's notify channel (size/last/valid/ready).
//  - Accepts one segment-completion notification per handshake and buffers it in a small FIFO.
//  - Tags each notification with a per-transfer sequence number and the running byte count of that transfer.
//  - Emits one 64-bit completion word per notification on a valid/ready stream to the host-notification path.
//  - Acceptance means "received" only; buffer space is the sole source of backpressure on the writer.

---
 rtl/stream_writer_notify_sink.sv | 164 ++++++++++++++++
 tb/tb_stream_writer_notify_sink.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_writer_notify_sink.sv
// stream_writer_notify_sink
//   Consumer side of the stream writer's notify channel. Each accepted
//   segment notification is buffered in a small FIFO. When it is popped
//   into the output register, it is tagged with a per-transfer sequence
//   number and the running byte count of its transfer. The result is
//   emitted as one 64-bit completion word on a valid/ready stream.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   in_size        bytes written in the completed segment
//   in_last        segment closes the current transfer
//   in_valid       notification valid
//   in_ready       notification accepted when in_valid & in_ready
//   out_data       {last, seq[14:0], cumulative bytes[47:0]}
//   out_valid      completion word valid
//   out_ready      downstream accepts when out_valid & out_ready
//   transfers_done count of last-flagged words handed downstream (mod 2^32)
//   idle           FIFO empty and output register empty
module stream_writer_notify_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int SIZE_BITS  = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SIZE_BITS-1:0] in_size,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [63:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          transfers_done,
  output logic                 idle
);

  localparam int             PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

  // Running byte count wraps silently at 2^48.
  function automatic logic [47:0] cum_add(input logic [47:0]          sum,
                                          input logic [SIZE_BITS-1:0] size);
    return sum + 48'(size);
  endfunction

  // Sequence number wraps 0x7FFF -> 0 through the natural 15-bit overflow.
  function automatic logic [14:0] seq_inc(input logic [14:0] seq);
    return seq + 15'd1;
  endfunction

  logic [SIZE_BITS:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       fifo_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 out_fire;
  logic                 head_last_p0;
  logic [SIZE_BITS-1:0] head_size_p0;
  logic [47:0]          cum_p0;
  logic [47:0]          sum_q;
  logic [14:0]          seq_q;
  logic [63:0]          data_p1;
  logic                 vld_p1;
  out_state_t           state;
  out_state_t           state_nxt;

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  // Full is judged before any same-cycle pop, so a full FIFO keeps in_ready
  // low even while the output register is draining.
  assign in_ready = rst_n & ~fifo_full;
  assign idle     = ~rst_n | (~vld_p1 & fifo_empty);

  assign push     = in_valid & in_ready;
  assign out_fire = vld_p1 & out_ready;
  assign pop      = ~fifo_empty & (~vld_p1 | out_ready);

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign vld_p1    = (state == OUT_FULL);

  // ---- stage p0: FIFO head and tagging arithmetic ----
  assign head_last_p0 = fifo_mem[rd_ptr][SIZE_BITS];
  assign head_size_p0 = fifo_mem[rd_ptr][SIZE_BITS-1:0];
  assign cum_p0       = cum_add(sum_q, head_size_p0);

  // FIFO storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_last, in_size};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      sum_q          <= '0;
      seq_q          <= '0;
      data_p1        <= '0;
      transfers_done <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
      // ---- stage p1: tagged word enters the output register ----
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        data_p1 <= {head_last_p0, seq_q, cum_p0};
        if (head_last_p0) begin
          sum_q <= '0;
          seq_q <= '0;
        end else begin
          sum_q <= cum_p0;
          seq_q <= seq_inc(seq_q);
        end
      end
      if (out_fire && data_p1[63]) transfers_done <= transfers_done + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= OUT_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (pop) state_nxt = OUT_FULL;
      OUT_FULL:  if (out_fire && fifo_empty) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

`ifndef SYNTHESIS
  logic        hold_q;
  logic [63:0] hold_data_q;

  always_ff @(posedge clk) begin
    hold_q      <= rst_n & out_valid & ~out_ready;
    hold_data_q <= out_data;
    if (rst_n) begin
      assert (!hold_q || (out_valid && out_data == hold_data_q))
        else $error("out_data/out_valid changed while stalled");
      assert (!$isunknown({in_valid, out_ready}))
        else $error("in_valid or out_ready is X");
      assert (!(push && fifo_full)) else $error("push into full FIFO");
      assert (!(pop && fifo_empty)) else $error("pop from empty FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_stream_writer_notify_sink.sv
module tb_stream_writer_notify_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] in_size = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] transfers_done;
  logic        idle;

  always #5 clk = ~clk;

  stream_writer_notify_sink #(.FIFO_DEPTH(4), .SIZE_BITS(48)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_size       (in_size),
    .in_last       (in_last),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .transfers_done(transfers_done),
    .idle          (idle)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [47:0] m_sum = '0;
  int          m_seq = 0;
  int          exp_done = 0;
  int          acc_cnt = 0;
  logic [63:0] last_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model and output monitor. Expected words are computed when a
  // notification is accepted: transfer byte total mod 2^48, sequence index
  // within the transfer mod 32768, both restarting after a last segment.
  always @(negedge clk) begin
    logic [63:0] e;
    logic [47:0] cum;
    if (!rst_n) begin
      exp_q.delete();
      m_sum    = '0;
      m_seq    = 0;
      exp_done = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_data: got 0x%h, want no word pending", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
          if (e[63]) exp_done++;
        end
        last_word = out_data;
      end
      if (in_valid && in_ready) begin
        cum = m_sum + in_size;
        exp_q.push_back({in_last, 15'(m_seq), cum});
        if (in_last) begin
          m_sum = '0;
          m_seq = 0;
        end else begin
          m_sum = cum;
          m_seq = (m_seq + 1) % 32768;
        end
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [47:0] sz, input logic lst);
    int n = 0;
    in_size  = sz;
    in_last  = lst;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) fail("send_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!idle && n < 300);
    check({name, "_idle"}, idle, 1);
    check({name, "_queue"}, exp_q.size(), 0);
    check({name, "_done"}, transfers_done, exp_done);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_idle", idle, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", transfers_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 1: basic transfer
    out_ready = 1'b1;
    send(48'h1000, 1'b0);
    send(48'h1000, 1'b0);
    send(48'h800, 1'b1);
    drain("t1");
    check("t1_last_word", last_word, 64'h8002_0000_0000_2800);
    check("t1_done", transfers_done, 1);

    // 2: backpressure, storage of FIFO_DEPTH+1
    out_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 5; i++) send(48'h40, 1'b0);
    in_size  = 48'h40;
    in_last  = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t2_accepted", acc_cnt - a0, 5);
    check("t2_in_ready", in_ready, 0);
    check("t2_out_valid", out_valid, 1);
    check("t2_hold_data", out_data, 64'h0000_0000_0000_0040);
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    if (!in_ready) fail("t2_sixth");
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t2_accepted6", acc_cnt - a0, 6);
    drain("t2");
    send(48'h0, 1'b1);
    drain("t2_close");

    // 3: 48-bit wrap of the running sum
    send(48'hFFFF_FFFF_FFF0, 1'b0);
    send(48'h20, 1'b0);
    send(48'h10, 1'b1);
    drain("t3");
    check("t3_last_word", last_word, 64'h8002_0000_0000_0020);

    // 4: sequence number wrap
    for (int i = 0; i < 32768; i++) send(48'h1, 1'b0);
    send(48'h1, 1'b1);
    drain("t4");
    check("t4_last_word", last_word, 64'h8000_0000_0000_8001);

    // 5: simultaneous push and pop around a full FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(48'h11 + 48'(i), 1'b0);
    @(negedge clk);
    check("t5_full", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_size   = 48'h21;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    check("t5_full_during_pop", in_ready, 0);
    @(posedge clk); #1;
    send(48'h21, 1'b0);
    send(48'h22, 1'b0);
    send(48'h23, 1'b1);
    drain("t5");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 3);
      case (r)
        0:       in_size = 48'h0;
        1:       in_size = 48'($urandom_range(1, 4096));
        2:       in_size = 48'({$urandom(), $urandom()});
        default: in_size = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 15));
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("rand");

    // 6: reset mid-operation discards everything
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(48'h100 + 48'(i), 1'b0);
    @(negedge clk);
    check("t6_pre_valid", out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_idle", idle, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_out_valid", out_valid, 0);
    check("t6_idle", idle, 1);
    check("t6_done", transfers_done, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(48'h100, 1'b1);
    drain("t6");
    check("t6_last_word", last_word, 64'h8000_0000_0000_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
